// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Command layer between uart_rx/uart_tx and the config regfile.
// Packet layout (request and reply): [17] parity, [16:9] addr, [8:1] data, [0] wrb.
// Requests must carry odd parity over all 18 bits. wrb=0 is a write, wrb=1 is a read.
// Only one packet is in flight at a time. uart_rx is unloaded only from IDLE,
// so later packets wait inside the receiver.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for uart_rx to hold a packet
// UNLOAD   | uld_rx_data pulse is out; capture the packet at this edge
// CHECK    | parity and address range check, error counting
// ACCESS   | issue the single-cycle regfile write or read strobe
// RDWAIT   | read strobe cycle, then the cycle where reg_rd_data is valid
// LOAD     | present the reply and handshake ld_tx_data against tx_busy
// BUSYWAIT | wait for uart_tx to finish shifting the reply
module uart_cmd_decoder #(
  parameter int NUMREGS   = 42,
  parameter int WORDWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [17:0]          rx_data,
  input  logic                 rx_empty,
  output logic                 uld_rx_data,
  output logic [17:0]          tx_data,
  output logic                 ld_tx_data,
  input  logic                 tx_busy,
  output logic [7:0]           reg_addr,
  output logic                 reg_wr_en,
  output logic [WORDWIDTH-1:0] reg_wr_data,
  output logic                 reg_rd_en,
  input  logic [WORDWIDTH-1:0] reg_rd_data,
  output logic [7:0]           parity_err_count,
  output logic [7:0]           range_err_count
);

  // Highest implemented regfile address; anything above it is a range error.
  localparam logic [7:0] LAST_ADDR = 8'(NUMREGS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UNLOAD   = 3'd1,
    S_CHECK    = 3'd2,
    S_ACCESS   = 3'd3,
    S_RDWAIT   = 3'd4,
    S_LOAD     = 3'd5,
    S_BUSYWAIT = 3'd6
  } state_t;

  state_t               r_state;
  logic [17:0]          r_pkt;
  logic                 r_rd_phase;
  logic                 r_uld;
  logic [17:0]          r_tx_data;
  logic                 r_ld;
  logic [7:0]           r_reg_addr;
  logic                 r_wr_en;
  logic [WORDWIDTH-1:0] r_wr_data;
  logic                 r_rd_en;
  logic [7:0]           r_par_cnt;
  logic [7:0]           r_rng_cnt;

  logic [7:0]           w_pkt_addr;
  logic [WORDWIDTH-1:0] w_pkt_data;
  logic                 w_pkt_wrb;
  logic                 w_par_ok;
  logic                 w_in_range;

  // Field extraction and checks on the held packet.
  assign w_pkt_addr = r_pkt[16:9];
  assign w_pkt_data = r_pkt[8:1];
  assign w_pkt_wrb  = r_pkt[0];
  assign w_par_ok   = ^r_pkt;
  assign w_in_range = (w_pkt_addr <= LAST_ADDR);

  // Build a reply with its parity bit chosen so the whole 18-bit word is odd.
  function automatic logic [17:0] mk_reply(input logic [7:0]           addr,
                                           input logic [WORDWIDTH-1:0] data,
                                           input logic                 wrb);
    logic [16:0] body;
    body = {addr, data, wrb};
    return {~^body, body};
  endfunction

  // Command sequencer with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pkt      <= '0;
      r_rd_phase <= 1'b0;
      r_uld      <= 1'b0;
      r_tx_data  <= '0;
      r_ld       <= 1'b0;
      r_reg_addr <= '0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_rd_en    <= 1'b0;
      r_par_cnt  <= '0;
      r_rng_cnt  <= '0;
    end else begin
      r_uld   <= 1'b0;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!rx_empty) begin
            r_uld   <= 1'b1;
            r_state <= S_UNLOAD;
          end
        end

        S_UNLOAD: begin
          r_pkt   <= rx_data;
          r_state <= S_CHECK;
        end

        S_CHECK: begin
          if (!w_par_ok) begin
            if (r_par_cnt != 8'hFF) r_par_cnt <= r_par_cnt + 8'd1;
            r_state <= S_IDLE;
          end else if (!w_in_range) begin
            // No regfile access; reads answer with zero data, writes echo.
            if (r_rng_cnt != 8'hFF) r_rng_cnt <= r_rng_cnt + 8'd1;
            r_tx_data <= mk_reply(w_pkt_addr, w_pkt_wrb ? '0 : w_pkt_data, w_pkt_wrb);
            r_state   <= S_LOAD;
          end else begin
            r_state <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          r_reg_addr <= w_pkt_addr;
          if (w_pkt_wrb) begin
            r_rd_en    <= 1'b1;
            r_rd_phase <= 1'b0;
            r_state    <= S_RDWAIT;
          end else begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_pkt_data;
            r_tx_data <= mk_reply(w_pkt_addr, w_pkt_data, 1'b0);
            r_state   <= S_LOAD;
          end
        end

        S_RDWAIT: begin
          // First cycle carries the strobe; read data is valid in the second.
          // ld_tx_data is raised on the way out so the read reply is not
          // delayed by a further cycle in LOAD.
          if (!r_rd_phase) begin
            r_rd_phase <= 1'b1;
          end else begin
            r_rd_phase <= 1'b0;
            r_tx_data  <= mk_reply(w_pkt_addr, reg_rd_data, 1'b1);
            r_ld       <= !tx_busy;
            r_state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          // Hold the request until uart_tx reports busy; never raise it while
          // an earlier transmission is still shifting.
          if (r_ld) begin
            if (tx_busy) begin
              r_ld    <= 1'b0;
              r_state <= S_BUSYWAIT;
            end
          end else if (!tx_busy) begin
            r_ld <= 1'b1;
          end
        end

        S_BUSYWAIT: begin
          if (!tx_busy) r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign uld_rx_data      = r_uld;
  assign tx_data          = r_tx_data;
  assign ld_tx_data       = r_ld;
  assign reg_addr         = r_reg_addr;
  assign reg_wr_en        = r_wr_en;
  assign reg_wr_data      = r_wr_data;
  assign reg_rd_en        = r_rd_en;
  assign parity_err_count = r_par_cnt;
  assign range_err_count  = r_rng_cnt;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder with small uart_rx, uart_tx and regfile models.
module tb_uart_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] rx_data;
  logic        rx_empty;
  logic        uld_rx_data;
  logic [17:0] tx_data;
  logic        ld_tx_data;
  logic        tx_busy;
  logic [7:0]  reg_addr;
  logic        reg_wr_en;
  logic [7:0]  reg_wr_data;
  logic        reg_rd_en;
  logic [7:0]  reg_rd_data = 8'h00;
  logic [7:0]  parity_err_count;
  logic [7:0]  range_err_count;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.NUMREGS(42), .WORDWIDTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_empty         (rx_empty),
    .uld_rx_data      (uld_rx_data),
    .tx_data          (tx_data),
    .ld_tx_data       (ld_tx_data),
    .tx_busy          (tx_busy),
    .reg_addr         (reg_addr),
    .reg_wr_en        (reg_wr_en),
    .reg_wr_data      (reg_wr_data),
    .reg_rd_en        (reg_rd_en),
    .reg_rd_data      (reg_rd_data),
    .parity_err_count (parity_err_count),
    .range_err_count  (range_err_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // regfile model: synchronous read, data valid the cycle after the strobe
  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (reg_wr_en) mem[reg_addr] <= reg_wr_data;
    if (reg_rd_en) reg_rd_data <= mem[reg_addr];
  end

  // uart_tx model: accepts a load when idle, stays busy for busy_len cycles
  int          busy_len = 4;
  int          tx_cnt   = 0;
  logic        model_busy = 1'b0;
  logic        tx_hold;
  logic [17:0] rep [0:63];
  int          rep_n = 0;
  assign tx_busy = model_busy | tx_hold;

  always @(posedge clk) begin
    if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) model_busy <= 1'b0;
    end else if (ld_tx_data && !tx_busy) begin
      model_busy <= 1'b1;
      tx_cnt     <= busy_len;
      if (rep_n < 64) rep[rep_n] <= tx_data;
      rep_n <= rep_n + 1;
    end
  end

  // cycle counter and negedge monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         wr_n = 0, wr_cyc = 0, rd_n = 0, rd_cyc = 0;
  int         ld_n = 0, ld_cyc = 0, both_n = 0, fall_cyc = 0;
  logic [7:0] wr_addr_seen = 8'h00, wr_data_seen = 8'h00;
  logic       ld_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_n++;
      wr_cyc       = cyc;
      wr_addr_seen = reg_addr;
      wr_data_seen = reg_wr_data;
    end
    if (reg_rd_en) begin
      rd_n++;
      rd_cyc = cyc;
    end
    if (reg_wr_en && reg_rd_en) both_n++;
    if (ld_tx_data && !ld_prev) begin
      ld_n++;
      ld_cyc = cyc;
    end
    if (!tx_busy && busy_prev) fall_cyc = cyc;
    ld_prev   = ld_tx_data;
    busy_prev = tx_busy;
  end

  // present a packet in uart_rx and wait for the decoder to unload it
  task automatic send_pkt(input logic [17:0] pkt, input int budget, output int uld_at);
    rx_data  = pkt;
    rx_empty = 1'b0;
    uld_at   = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (uld_rx_data) begin
        uld_at = cyc;
        break;
      end
    end
    if (uld_at < 0) check_eq("uld_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    rx_empty = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int u, u2, wr0, rd0, ld0, rn0;
  logic seen;

  initial begin
    reset    = 1'b1;
    rx_empty = 1'b1;
    rx_data  = '0;
    tx_hold  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    wait_cycles(3);

    // reset state
    check_eq("rst_uld", uld_rx_data, 0);
    check_eq("rst_ld", ld_tx_data, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_wr_en", reg_wr_en, 0);
    check_eq("rst_rd_en", reg_rd_en, 0);
    check_eq("rst_par_cnt", parity_err_count, 0);
    check_eq("rst_rng_cnt", range_err_count, 0);
    reset = 1'b0;
    wait_cycles(2);

    // write addr 0x05 data 0xA5
    wr0 = wr_n; ld0 = ld_n; rn0 = rep_n;
    send_pkt(18'h20B4A, 50, u);
    wait_cycles(15);
    check_eq("wr_count", wr_n - wr0, 1);
    check_eq("wr_addr", wr_addr_seen, 8'h05);
    check_eq("wr_data", wr_data_seen, 8'hA5);
    check_eq("wr_latency", wr_cyc - u, 3);
    check_eq("wr_ld_latency", ld_cyc - u, 4);
    check_eq("wr_reply_count", rep_n - rn0, 1);
    check_eq("wr_reply", rep[rn0], 18'h20B4A);

    // read addr 0x05, regfile returns 0xA5
    wr0 = wr_n; rd0 = rd_n; rn0 = rep_n;
    send_pkt(18'h00A01, 50, u);
    wait_cycles(15);
    check_eq("rd_count", rd_n - rd0, 1);
    check_eq("rd_no_wr", wr_n - wr0, 0);
    check_eq("rd_latency", rd_cyc - u, 3);
    check_eq("rd_ld_latency", ld_cyc - u, 5);
    check_eq("rd_reply", rep[rn0], 18'h00B4B);

    // bad parity write to addr 0x01
    wr0 = wr_n; rd0 = rd_n; ld0 = ld_n; rn0 = rep_n;
    send_pkt(18'h20200, 50, u);
    wait_cycles(10);
    check_eq("par_no_wr", wr_n - wr0, 0);
    check_eq("par_no_rd", rd_n - rd0, 0);
    check_eq("par_no_ld", ld_n - ld0, 0);
    check_eq("par_cnt_1", parity_err_count, 8'h01);

    // read addr 0x2A, one past the last register
    rd0 = rd_n; rn0 = rep_n;
    send_pkt(18'h25401, 50, u);
    wait_cycles(15);
    check_eq("rng_no_rd", rd_n - rd0, 0);
    check_eq("rng_reply", rep[rn0], 18'h25401);
    check_eq("rng_cnt_1", range_err_count, 8'h01);
    check_eq("rng_par_cnt", parity_err_count, 8'h01);

    // write last valid addr 0x29 data 0xFF while uart_tx is still busy
    tx_hold = 1'b1;
    wr0 = wr_n; ld0 = ld_n; rn0 = rep_n;
    send_pkt(18'h053FE, 50, u);
    wait_cycles(15);
    check_eq("hold_wr_count", wr_n - wr0, 1);
    check_eq("hold_wr_addr", wr_addr_seen, 8'h29);
    check_eq("hold_no_ld", ld_n - ld0, 0);
    tx_hold = 1'b0;
    wait_cycles(15);
    check_eq("hold_ld_after", ld_n - ld0, 1);
    check_eq("hold_reply", rep[rn0], 18'h053FE);

    // back-to-back writes with a 200-cycle transmission
    busy_len = 200;
    rn0 = rep_n;
    send_pkt(18'h02078, 50, u);
    send_pkt(18'h2221E, 400, u2);
    check_eq("b2b_uld_after_fall", u2 > fall_cyc, 1);
    check_eq("b2b_uld_gap", (u2 - u) > 200, 1);
    wait_cycles(230);
    check_eq("b2b_reply_count", rep_n - rn0, 2);
    check_eq("b2b_reply_0", rep[rn0], 18'h02078);
    check_eq("b2b_reply_1", rep[rn0 + 1], 18'h2221E);
    busy_len = 4;
    wait_cycles(5);

    // 299 more bad packets: 300 total, count saturates
    for (int i = 0; i < 299; i++) send_pkt(18'h20200, 50, u);
    wait_cycles(5);
    check_eq("par_cnt_sat", parity_err_count, 8'hFF);

    // reset while in RDWAIT (read addr 0x03)
    ld0 = ld_n; rn0 = rep_n;
    send_pkt(18'h00601, 50, u);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (reg_rd_en) seen = 1'b1;
    end
    check_eq("rst_rd_seen", seen, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_ld", ld_tx_data, 0);
    check_eq("mid_rst_rd_en", reg_rd_en, 0);
    check_eq("mid_rst_tx_data", tx_data, 0);
    check_eq("mid_rst_addr", reg_addr, 0);
    check_eq("mid_rst_par_cnt", parity_err_count, 0);
    check_eq("mid_rst_rng_cnt", range_err_count, 0);
    reset = 1'b0;
    wait_cycles(20);
    check_eq("mid_rst_no_ld", ld_n - ld0, 0);
    check_eq("mid_rst_no_reply", rep_n - rn0, 0);

    // write addr 0x07 data 0x5A after the reset
    wr0 = wr_n; rn0 = rep_n;
    send_pkt(18'h00EB4, 50, u);
    wait_cycles(15);
    check_eq("post_wr_count", wr_n - wr0, 1);
    check_eq("post_wr_addr", wr_addr_seen, 8'h07);
    check_eq("post_wr_data", wr_data_seen, 8'h5A);
    check_eq("post_wr_latency", wr_cyc - u, 3);
    check_eq("post_reply", rep[rn0], 18'h00EB4);

    check_eq("no_dual_strobe", both_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
